// File: rtl/udp_frame_pkg.sv
// rtl/udp_frame_pkg.sv - Frame constants, state encoding and header ROM for udp_frame_sequencer
// The 42-byte Ethernet/IPv4/UDP header, with its IPv4 checksum, is fixed once PAYLOAD_LEN is known.
package udp_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_APPHDR,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int HDR_LEN      = 42;
  localparam int APPHDR_LEN   = 4;
  localparam int IFG_LEN      = 12;
  localparam int IP_HDR_LEN   = 20;
  localparam int UDP_HDR_LEN  = 8;

  localparam logic [10:0] PREAMBLE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] HDR_LAST      = 11'(HDR_LEN - 1);
  localparam logic [10:0] APPHDR_LAST   = 11'(APPHDR_LEN - 1);
  localparam logic [10:0] IFG_LAST      = 11'(IFG_LEN - 1);

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [47:0] DST_MAC        = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SRC_MAC        = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [31:0] SRC_IP         = 32'hC0A8_010A;
  localparam logic [31:0] DST_IP         = 32'hC0A8_0114;
  localparam logic [15:0] SRC_PORT       = 16'd5000;
  localparam logic [15:0] DST_PORT       = 16'd5001;
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  function automatic logic [7:0] hdr_byte(input logic [10:0] idx, input int unsigned plen);
    logic [15:0]            ip_len;
    logic [15:0]            udp_len;
    logic [159:0]           ip;
    logic [31:0]            sum;
    logic [HDR_LEN*8-1:0]   hdr;
    ip_len  = 16'(IP_HDR_LEN + UDP_HDR_LEN + APPHDR_LEN + plen);
    udp_len = 16'(UDP_HDR_LEN + APPHDR_LEN + plen);
    ip = {8'h45, 8'h00, ip_len, 16'h0000, 16'h0000, IP_TTL, IP_PROTO_UDP, 16'h0000, SRC_IP, DST_IP};
    sum = 32'h0;
    for (int w = 0; w < 10; w++) begin
      sum = sum + 32'(ip[w*16 +: 16]);
    end
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    ip[79:64] = ~sum[15:0];
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, ip, SRC_PORT, DST_PORT, udp_len, 16'h0000};
    if (idx < 11'(HDR_LEN)) begin
      return hdr[(HDR_LEN - 1 - int'(idx))*8 +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/crc32_eth8.sv
// rtl/crc32_eth8.sv - Byte-wide reflected Ethernet CRC-32 accumulator
// crc holds the running register; the caller complements it to form the FCS.
module crc32_eth8
  import udp_frame_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] step;

  always_comb begin
    step = crc_q ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      step = step[0] ? ((step >> 1) ^ CRC32_POLY_REFL) : (step >> 1);
    end
    crc_d = crc_q;
    if (init) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (en) begin
      crc_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/udp_frame_sequencer.sv
// rtl/udp_frame_sequencer.sv - Byte-serial Ethernet/IPv4/UDP frame generator for the GMII TX path
// Define UDP_FRAME_FCS_EN to append the CRC-32 FCS here; otherwise the MAC is expected to add it.
module udp_frame_sequencer
  import udp_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 1000,
  parameter int unsigned RAM_AW      = 24
) (
  input  logic              clk125MHz,
  input  logic              RST,
  input  logic              start_sending,
  input  logic [15:0]       segment_num,
  input  logic [7:0]        txid,
  input  logic [7:0]        aux,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_en
);

  localparam logic [10:0] PAYLOAD_LAST = 11'(PAYLOAD_LEN - 1);

  state_t            state_q, state_d;
  logic [10:0]       idx_q, idx_d;
  logic [15:0]       seg_q, seg_d;
  logic [7:0]        txid_q, txid_d;
  logic [7:0]        aux_q, aux_d;
  logic              busy_q, busy_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_AW-1:0] seg_base;

  assign seg_base = RAM_AW'(seg_q) * RAM_AW'(PAYLOAD_LEN);

`ifdef UDP_FRAME_FCS_EN
  localparam logic [10:0] FCS_LAST = 11'd3;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic        crc_en;
  logic        crc_init;

  // The CRC absorbs each byte on the same edge that registers it onto tx_data.
  assign crc_init = (state_d == ST_PREAMBLE);
  assign crc_en   = (state_d == ST_HEADER) || (state_d == ST_APPHDR) || (state_d == ST_PAYLOAD);
  assign fcs      = ~crc;

  crc32_eth8 u_crc (
    .clk  (clk125MHz),
    .RST  (RST),
    .init (crc_init),
    .en   (crc_en),
    .d    (tx_data_d),
    .crc  (crc)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + 11'd1;
    seg_d   = seg_q;
    txid_d  = txid_q;
    aux_d   = aux_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = 11'd0;
        if (start_sending) begin
          state_d = ST_PREAMBLE;
          seg_d   = segment_num;
          txid_d  = txid;
          aux_d   = aux;
        end
      end
      ST_PREAMBLE: if (idx_q == PREAMBLE_LAST) begin state_d = ST_HEADER;  idx_d = 11'd0; end
      ST_HEADER:   if (idx_q == HDR_LAST)      begin state_d = ST_APPHDR;  idx_d = 11'd0; end
      ST_APPHDR:   if (idx_q == APPHDR_LAST)   begin state_d = ST_PAYLOAD; idx_d = 11'd0; end
      ST_PAYLOAD: begin
        if (idx_q == PAYLOAD_LAST) begin
`ifdef UDP_FRAME_FCS_EN
          state_d = ST_FCS;
`else
          state_d = ST_IFG;
`endif
          idx_d = 11'd0;
        end
      end
`ifdef UDP_FRAME_FCS_EN
      ST_FCS:      if (idx_q == FCS_LAST)      begin state_d = ST_IFG;     idx_d = 11'd0; end
`endif
      ST_IFG:      if (idx_q == IFG_LAST)      begin state_d = ST_IDLE;    idx_d = 11'd0; end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 11'd0;
      end
    endcase

    // Outputs are decoded from the next state so every output leaves a flop.
    busy_d  = (state_d != ST_IDLE);
    tx_en_d = (state_d != ST_IDLE) && (state_d != ST_IFG);
    case (state_d)
      ST_PREAMBLE: tx_data_d = (idx_d == PREAMBLE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      ST_HEADER:   tx_data_d = hdr_byte(idx_d, PAYLOAD_LEN);
      ST_APPHDR: begin
        case (idx_d[1:0])
          2'd0:    tx_data_d = txid_q;
          2'd1:    tx_data_d = aux_q;
          2'd2:    tx_data_d = seg_q[15:8];
          default: tx_data_d = seg_q[7:0];
        endcase
      end
      ST_PAYLOAD:  tx_data_d = ram_rdata;
`ifdef UDP_FRAME_FCS_EN
      ST_FCS:      tx_data_d = fcs[8*idx_d[1:0] +: 8];
`endif
      default:     tx_data_d = 8'h00;
    endcase

    // Address runs one byte ahead of tx_data so ram_rdata lines up with the payload slot.
    ram_addr_d = ram_addr_q;
    if ((state_d == ST_APPHDR) && (idx_d == APPHDR_LAST)) begin
      ram_addr_d = seg_base;
    end else if ((state_d == ST_PAYLOAD) && (idx_d != PAYLOAD_LAST)) begin
      ram_addr_d = ram_addr_q + RAM_AW'(1);
    end
  end

  always_ff @(posedge clk125MHz) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 11'd0;
      seg_q      <= 16'h0;
      txid_q     <= 8'h0;
      aux_q      <= 8'h0;
      busy_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      txid_q     <= txid_d;
      aux_q      <= aux_d;
      busy_q     <= busy_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign busy     = busy_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_udp_frame_sequencer.sv
// tb/tb_udp_frame_sequencer.sv - Directed self-checking bench for udp_frame_sequencer
module tb_udp_frame_sequencer;

  localparam int LEN = 1000;
  localparam int AW  = 24;
`ifdef UDP_FRAME_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif
  localparam int EN_LEN   = 54 + LEN + FCS_N;
  localparam int BUSY_LEN = EN_LEN + 12;
  localparam int NCAP     = BUSY_LEN + 32;

  logic          clk125MHz = 1'b0;
  logic          RST = 1'b1;
  logic          start_sending = 1'b0;
  logic [15:0]   segment_num = 16'h0;
  logic [7:0]    txid = 8'h0;
  logic [7:0]    aux = 8'h0;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic [7:0]    tx_data;
  logic          tx_en;

  int total = 0;
  int bad   = 0;

  logic [7:0]    cap_d    [NCAP];
  logic          cap_en   [NCAP];
  logic          cap_busy [NCAP];
  logic [AW-1:0] cap_addr [NCAP];

  always #4 clk125MHz = ~clk125MHz;

  assign ram_rdata = ram_addr[7:0];

  udp_frame_sequencer #(.PAYLOAD_LEN(LEN), .RAM_AW(AW)) dut (
    .clk125MHz     (clk125MHz),
    .RST           (RST),
    .start_sending (start_sending),
    .segment_num   (segment_num),
    .txid          (txid),
    .aux           (aux),
    .busy          (busy),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata),
    .tx_data       (tx_data),
    .tx_en         (tx_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [15:0] seg, input logic [7:0] t, input logic [7:0] a);
    start_sending = 1'b1;
    segment_num   = seg;
    txid          = t;
    aux           = a;
    @(negedge clk125MHz);
    start_sending = 1'b0;
    segment_num   = 16'hDEAD;
    txid          = 8'hEE;
    aux           = 8'hEE;
  endtask

  // Sample index s is the s-th cycle after the accepting edge; extra pulses go out at p1/p2.
  task automatic capture(input int n, input int p1, input int p2,
                         input logic [15:0] seg2, input logic [7:0] t2, input logic [7:0] a2);
    for (int s = 0; s < n; s++) begin
      cap_d[s]    = tx_data;
      cap_en[s]   = tx_en;
      cap_busy[s] = busy;
      cap_addr[s] = ram_addr;
      if (s == p1 || s == p2) begin
        start_sending = 1'b1;
        segment_num   = seg2;
        txid          = t2;
        aux           = a2;
      end else begin
        start_sending = 1'b0;
      end
      @(negedge clk125MHz);
    end
    start_sending = 1'b0;
  endtask

`ifdef UDP_FRAME_FCS_EN
  function automatic logic [31:0] sw_crc(input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = from; i <= to; i++) begin
      c = c ^ {24'h0, cap_d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  task automatic check_frame(input string pf, input logic [7:0] t, input logic [7:0] a,
                             input logic [15:0] seg, input logic [AW-1:0] base);
    int          en_cnt;
    int          busy_cnt;
    logic [31:0] sum;
    logic [AW-1:0] ea;
    en_cnt   = 0;
    busy_cnt = 0;
    for (int s = 0; s <= BUSY_LEN; s++) begin
      if (cap_en[s])   en_cnt++;
      if (cap_busy[s]) busy_cnt++;
    end
    check({pf, "first_en"},   {31'h0, cap_en[0]},            32'd1);
    check({pf, "last_en"},    {31'h0, cap_en[EN_LEN-1]},     32'd1);
    check({pf, "en_cycles"},  en_cnt,                        EN_LEN);
    check({pf, "busy_cycles"}, busy_cnt,                     BUSY_LEN);
    check({pf, "busy_fall"},  {31'h0, cap_busy[BUSY_LEN]},   32'd0);
    for (int i = 0; i < 7; i++) check({pf, "preamble"}, cap_d[i], 8'h55);
    check({pf, "sfd"},        cap_d[7],  8'hD5);
    check({pf, "ethtype_hi"}, cap_d[20], 8'h08);
    check({pf, "ethtype_lo"}, cap_d[21], 8'h00);
    check({pf, "ip_vihl"},    cap_d[22], 8'h45);
    check({pf, "ip_len"},     {cap_d[24], cap_d[25]}, 16'h0408);
    check({pf, "ip_ttl"},     cap_d[30], 8'h40);
    check({pf, "ip_proto"},   cap_d[31], 8'h11);
    check({pf, "udp_len"},    {cap_d[46], cap_d[47]}, 16'h03F4);
    check({pf, "udp_csum"},   {cap_d[48], cap_d[49]}, 16'h0000);
    sum = 32'h0;
    for (int w = 0; w < 10; w++) sum = sum + {16'h0, cap_d[22+2*w], cap_d[23+2*w]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    check({pf, "ip_csum_verify"}, sum[15:0], 16'hFFFF);
    check({pf, "app_txid"},   cap_d[50], t);
    check({pf, "app_aux"},    cap_d[51], a);
    check({pf, "app_seg_hi"}, cap_d[52], seg[15:8]);
    check({pf, "app_seg_lo"}, cap_d[53], seg[7:0]);
    for (int i = 0; i < LEN; i++) begin
      ea = base + AW'(i);
      check({pf, "ram_addr"}, cap_addr[53+i], ea);
      check({pf, "payload"},  cap_d[54+i],    ea[7:0]);
    end
`ifdef UDP_FRAME_FCS_EN
    sum = sw_crc(8, 53 + LEN);
    for (int k = 0; k < 4; k++) check({pf, "fcs"}, cap_d[54+LEN+k], sum[8*k +: 8]);
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_err;
    int guard;
    repeat (3) @(negedge clk125MHz);
    check("rst_busy",  {31'h0, busy},  32'd0);
    check("rst_tx_en", {31'h0, tx_en}, 32'd0);
    check("rst_txd",   tx_data,        8'h00);
    check("rst_addr",  ram_addr,       24'h0);
    RST = 1'b0;
    idle_err = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk125MHz);
      if (busy !== 1'b0 || tx_en !== 1'b0 || tx_data !== 8'h00) idle_err++;
    end
    check("idle_quiet", idle_err, 0);

    // A: start mid-frame at cycle 10 must be ignored
    start_frame(16'h0102, 8'h02, 8'h07);
    capture(NCAP, 10, -1, 16'h0BAD, 8'h99, 8'h98);
    check_frame("A_", 8'h02, 8'h07, 16'h0102, 24'd258000);

    // B: address wraps mod 2^24; start on last busy cycle ignored, on first idle cycle accepted
    start_frame(16'hFFFF, 8'hA5, 8'h3C);
    capture(BUSY_LEN + 3, BUSY_LEN - 1, BUSY_LEN, 16'h0004, 8'h11, 8'h22);
    check_frame("B_", 8'hA5, 8'h3C, 16'hFFFF, 24'hE7FC18);
    check("B_restart_en",   {31'h0, cap_en[BUSY_LEN+1]},   32'd1);
    check("B_restart_busy", {31'h0, cap_busy[BUSY_LEN+1]}, 32'd1);
    check("B_restart_txd",  cap_d[BUSY_LEN+1],             8'h55);
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk125MHz);
      guard++;
    end
    check("B_drain", {31'h0, busy}, 32'd0);

    // C: reset at payload byte 300, with a simultaneous start that must be dropped
    start_frame(16'h0003, 8'h01, 8'h09);
    capture(354, -1, -1, 16'h0, 8'h0, 8'h0);
    check("C_pay300_en",  {31'h0, tx_en}, 32'd1);
    check("C_pay300_txd", tx_data,        8'hE4);
    RST = 1'b1;
    start_sending = 1'b1;
    segment_num = 16'h0007;
    @(negedge clk125MHz);
    check("C_rst_busy",  {31'h0, busy},  32'd0);
    check("C_rst_tx_en", {31'h0, tx_en}, 32'd0);
    check("C_rst_txd",   tx_data,        8'h00);
    check("C_rst_addr",  ram_addr,       24'h0);
    RST = 1'b0;
    start_sending = 1'b0;
    @(negedge clk125MHz);
    check("C_drop_busy",  {31'h0, busy},  32'd0);
    check("C_drop_tx_en", {31'h0, tx_en}, 32'd0);

    // D: clean frame after the truncated one
    start_frame(16'h0003, 8'h01, 8'h09);
    capture(NCAP, -1, -1, 16'h0, 8'h0, 8'h0);
    check_frame("D_", 8'h01, 8'h09, 16'h0003, 24'd3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udp_frame_sequencer.md
# udp_frame_sequencer

Byte-level Ethernet/IPv4/UDP frame generator sitting directly downstream of the send scheduler. On each `start_sending` pulse it latches the segment descriptor (`segment_num`, `txid`, `aux`) and streams one complete frame (preamble, headers, application header, payload read from the segment RAM, FCS) to the GMII transmit path. It holds `busy` through the frame and the inter-frame gap so the scheduler cannot issue overlapping requests.

## Interface
- `PAYLOAD_LEN`, 1000, payload bytes per segment; legal range 14..1468.
- `RAM_AW`, 24, segment RAM address width.
- `clk125MHz  in  1  clock`
- `RST  in  1  reset, synchronous, active-high`
- `start_sending  in  1  one-cycle request pulse from scheduler`
- `segment_num  in  16  segment index, valid with start_sending`
- `txid  in  8  redundancy copy id, valid with start_sending`
- `aux  in  8  round counter, valid with start_sending`
- `busy  out  1  high from frame start through end of IFG`
- `ram_addr  out  RAM_AW  payload RAM read address`
- `ram_rdata  in  8  payload RAM data, 1-cycle read latency`
- `tx_data  out  8  GMII TXD`
- `tx_en  out  1  GMII TX_EN`

## Operation
- States: IDLE, PREAMBLE, HEADER, APPHDR, PAYLOAD, FCS, IFG; byte counter `idx` (11 bit) reset to 0 on each state entry.
- IDLE: `start_sending`=1 → latch descriptor, go PREAMBLE. `start_sending` while not IDLE is ignored (no queueing).
- PREAMBLE: 7×0x55, then 0xD5 (8 bytes).
- HEADER: 42 bytes from package function `hdr_byte(idx, PAYLOAD_LEN)`: dst MAC, src MAC, 0x0800, IPv4 header (total length 28+4+PAYLOAD_LEN, TTL 64, proto 17, checksum computed at elaboration), UDP header (length 8+4+PAYLOAD_LEN, checksum 0x0000).
- APPHDR: `txid`, `aux`, `segment_num[15:8]`, `segment_num[7:0]`.
- PAYLOAD: PAYLOAD_LEN bytes of `ram_rdata`; `ram_addr = segment_num*PAYLOAD_LEN + i`, issued one cycle ahead (first address driven during last APPHDR byte). Address arithmetic in RAM_AW bits, wraps modulo 2^RAM_AW.
- FCS: 4 bytes, CRC-32 (poly 0x04C11DB7 reflected, init 0xFFFFFFFF, final complement) over HEADER..PAYLOAD, LSB byte first.
- IFG: 12 cycles, `tx_en`=0, `busy`=1; then IDLE.

## Timing
- Reset values: `busy`=0, `tx_en`=0, `tx_data`=0x00, `ram_addr`=0, state IDLE, CRC = 0xFFFFFFFF.
- `start_sending` sampled high at edge T → `busy`=1 and `tx_en`=1 with first 0x55 registered at T+1.
- `tx_en` high for exactly 58+PAYLOAD_LEN cycles; `busy` high for 70+PAYLOAD_LEN cycles; earliest next accepted start is the cycle `busy` reads 0.
- All outputs registered; no combinational path input→output.
- RST mid-frame: next cycle all outputs at reset values, frame truncated, descriptor discarded.
- RST and `start_sending` simultaneously: RST wins, request dropped.

## Configuration
- `UDP_FRAME_FCS_EN` defined: CRC generator instantiated, FCS state emitted; frame = 58+PAYLOAD_LEN bytes.
- Undefined: no CRC logic, PAYLOAD → IFG directly (MAC appends FCS); frame = 54+PAYLOAD_LEN bytes, `busy` = 66+PAYLOAD_LEN cycles.

## Structure
- Package `udp_frame_pkg`: MAC/IP/port constants, state enum, `PREAMBLE_LEN`=8, `HDR_LEN`=42, `APPHDR_LEN`=4, `IFG_LEN`=12, function `hdr_byte` including IPv4 checksum computation.
- Sub-module `crc32_eth8`: byte-wide CRC-32, ports clk, RST, init, en, d[7:0], crc[31:0].

## Test plan
- Reset then idle 100 cycles → `busy`=0, `tx_en`=0, `tx_data`=0x00 throughout.
- PAYLOAD_LEN=1000, start with segment_num=0x0102, txid=2, aux=7 → bytes 50..53 of the stream = 0x02,0x07,0x01,0x02; `ram_addr` sequence 258000..258999; `tx_en` high 1058 cycles.
- RAM model data = addr[7:0] → FCS matches software CRC-32 reference; IPv4 checksum verifies to 0xFFFF in receiver model.
- `start_sending` pulsed at cycle 10 of a frame → ignored; exactly one frame emitted; second start accepted only after `busy` falls (1070 cycles after the first).
- RST asserted at payload byte 300 → next cycle `tx_en`=0, `busy`=0; fresh start then produces a complete, correct frame.
- Build without `UDP_FRAME_FCS_EN`, PAYLOAD_LEN=14 → 68-byte `tx_en` window, `busy` 80 cycles, last `tx_en` byte = last payload byte.
